// File: rtl/datapath_sequencer.sv
// Sequences the a0 datapath selects and write strobe for one instruction at a time.
// Accepts in IDLE only, so the source holds instr_valid while the controller is busy. Done trails the accept by 3 cycles (NOP), 5 (single write) or 3+2k (k-write REPSUB).
module datapath_sequencer #(
  parameter int INSTR_W = 16,
  parameter int CNT_W   = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic               sub_zero,
  output logic               CTRL1,
  output logic               CTRL5,
  output logic               CTRL6,
  output logic               a0_we,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [CNT_W-1:0]   iter_count
);

  localparam logic [3:0] OP_NOP    = 4'd0;
  localparam logic [3:0] OP_LDI    = 4'd1;
  localparam logic [3:0] OP_MOVA1  = 4'd2;
  localparam logic [3:0] OP_SUB    = 4'd3;
  localparam logic [3:0] OP_REPSUB = 4'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_WRITE,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] iter_q, iter_d;
  logic [CNT_W-1:0] iter_inc;
  logic             ctrl1_q, ctrl1_d;
  logic             ctrl5_q, ctrl5_d;
  logic             ctrl6_q, ctrl6_d;
  logic             we_q, we_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             sel_active;

  // Only the opcode and count fields matter; the bits between them are ignored.
  generate
    if (INSTR_W - 4 > CNT_W) begin : g_mid_bits
      logic unused_mid_bits;
      assign unused_mid_bits = ^instr[INSTR_W-5:CNT_W];
    end
  endgenerate

  assign iter_inc = iter_q + {{(CNT_W-1){1'b0}}, 1'b1};

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    iter_d  = iter_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          op_d    = instr[INSTR_W-1:INSTR_W-4];
          cnt_d   = instr[CNT_W-1:0];
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        case (op_q)
          OP_NOP:                   state_d = S_DONE;
          OP_LDI, OP_MOVA1, OP_SUB: state_d = S_EXEC;
          OP_REPSUB: begin
            iter_d  = '0;
            state_d = (cnt_q == '0) ? S_DONE : S_EXEC;
          end
          default: begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        endcase
      end
      S_EXEC: state_d = S_WRITE;
      S_WRITE: begin
        if (op_q == OP_REPSUB) begin
          iter_d  = iter_inc;
          // sub_zero reflects a0 before this write lands
          state_d = ((iter_inc == cnt_q) || sub_zero) ? S_DONE : S_EXEC;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Selects follow the next state so they line up with EXEC/WRITE cycles.
    sel_active = (state_d == S_EXEC) || (state_d == S_WRITE);
    ctrl1_d    = sel_active && (op_q == OP_LDI);
    ctrl5_d    = sel_active && (op_q == OP_MOVA1);
    ctrl6_d    = sel_active && ((op_q == OP_SUB) || (op_q == OP_REPSUB));
    we_d       = (state_d == S_WRITE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
      iter_q  <= '0;
      ctrl1_q <= 1'b0;
      ctrl5_q <= 1'b0;
      ctrl6_q <= 1'b0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      iter_q  <= iter_d;
      ctrl1_q <= ctrl1_d;
      ctrl5_q <= ctrl5_d;
      ctrl6_q <= ctrl6_d;
      we_q    <= we_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign instr_ready = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign CTRL1       = ctrl1_q;
  assign CTRL5       = ctrl5_q;
  assign CTRL6       = ctrl6_q;
  assign a0_we       = we_q;
  assign done        = done_q;
  assign err         = err_q;
  assign iter_count  = iter_q;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Bench for datapath_sequencer: offset-based reference model checked every cycle, plus directed literal scenarios.
module tb_datapath_sequencer;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [15:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic        sub_zero = 1'b0;
  logic        instr_ready, CTRL1, CTRL5, CTRL6, a0_we, busy, done, err;
  logic [7:0]  iter_count;

  always #5 CLK = ~CLK;

  datapath_sequencer #(.INSTR_W(16), .CNT_W(8)) dut (
    .CLK(CLK), .RST(RST), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .sub_zero(sub_zero),
    .CTRL1(CTRL1), .CTRL5(CTRL5), .CTRL6(CTRL6), .a0_we(a0_we),
    .busy(busy), .done(done), .err(err), .iter_count(iter_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: each instruction is a timeline indexed by t = cycles since its accept edge.
  // DECODE at t=1; EXEC/WRITE alternate from t=2 with writes on odd t; the last busy cycle
  // (DONE) is m_last; done pulses at m_last+1; an illegal opcode pulses err at t=2.
  bit m_active = 0;
  int m_t = 0, m_op = 0, m_n = 0, m_w = 0, m_last = 0, m_iter = 0;

  function automatic bit m_legal();  return m_op <= 4; endfunction
  function automatic bit m_busy();   return m_active && m_t >= 1 && m_t <= m_last; endfunction
  function automatic bit m_sel();    return m_busy() && m_legal() && m_op != 0 && m_t >= 2 && m_t <= m_last - 1; endfunction
  function automatic bit m_we();     return m_sel() && (m_t % 2 == 1); endfunction
  function automatic bit m_done();   return m_active && m_legal() && m_t == m_last + 1; endfunction
  function automatic bit m_err();    return m_active && !m_legal() && m_t == 2; endfunction

  always @(posedge CLK) begin
    if (RST) begin
      m_active = 0; m_t = 0; m_iter = 0;
    end else begin
      bit acc;
      acc = !m_busy() && instr_valid;
      if (m_we() && m_op == 4) begin
        m_w++;
        m_iter = m_w;
        if (m_w == m_n || sub_zero) m_last = m_t + 1;
      end
      if (m_busy() && m_t == 1 && m_op == 4) m_iter = 0;
      if (acc) begin
        m_active = 1; m_t = 1; m_w = 0;
        m_op = int'(instr[15:12]);
        m_n  = int'(instr[7:0]);
        if (m_op == 0)      m_last = 2;
        else if (m_op <= 3) m_last = 4;
        else if (m_op == 4) m_last = (m_n == 0) ? 2 : 32'h3fff_ffff;
        else                m_last = 1;
      end else if (m_active) begin
        m_t++;
        if (m_t > m_last + 1) m_active = 0;
      end
    end
  end

  always @(negedge CLK) begin
    if (!RST) begin
      check("instr_ready", instr_ready, !m_busy());
      check("busy",        busy,        m_busy());
      check("CTRL1",       CTRL1,       m_sel() && m_op == 1);
      check("CTRL5",       CTRL5,       m_sel() && m_op == 2);
      check("CTRL6",       CTRL6,       m_sel() && (m_op == 3 || m_op == 4));
      check("a0_we",       a0_we,       m_we());
      check("done",        done,        m_done());
      check("err",         err,         m_err());
      check("iter_count",  iter_count,  m_iter);
      check("ctrl_onehot0", $onehot0({CTRL1, CTRL5, CTRL6}), 1);
    end
  end

  // Event log: cycle index of accepts, done/err pulses and writes (with selects at write).
  int cyc = 0;
  int acc_q[$], done_q[$], err_q[$], we_q[$];
  logic [2:0] sel_q[$];

  always @(posedge CLK) begin
    if (!RST) begin
      if (instr_valid && instr_ready) acc_q.push_back(cyc);
      if (done) done_q.push_back(cyc);
      if (err)  err_q.push_back(cyc);
      if (a0_we) begin
        we_q.push_back(cyc);
        sel_q.push_back({CTRL1, CTRL5, CTRL6});
      end
    end
    cyc++;
  end

  task automatic clear_logs();
    acc_q.delete(); done_q.delete(); err_q.delete(); we_q.delete(); sel_q.delete();
  endtask

  // Issue one instruction (called at a negedge); raise sub_zero during write number szw.
  task automatic run(input logic [15:0] w, input int szw);
    int  wc;
    bit  fin;
    wc = 0; fin = 0;
    clear_logs();
    instr = w; instr_valid = 1'b1;
    for (int i = 0; i < 100 && !fin; i++) begin
      @(negedge CLK);
      if (acc_q.size() > 0) instr_valid = 1'b0;
      if (a0_we) wc++;
      sub_zero = a0_we && (wc == szw);
      if (done || err) fin = 1;
    end
    sub_zero = 1'b0;
    if (!fin) check("run_timeout", 0, 1);
    @(negedge CLK);
  endtask

  task automatic expect_run(input string nm, input int lat, input int writes, input bit is_err);
    check({nm, "_accepts"}, acc_q.size(), 1);
    check({nm, "_writes"}, we_q.size(), writes);
    check({nm, "_dones"}, done_q.size(), is_err ? 0 : 1);
    check({nm, "_errs"}, err_q.size(), is_err ? 1 : 0);
    if (acc_q.size() == 1 && !is_err && done_q.size() == 1) check({nm, "_done_lat"}, done_q[0] - acc_q[0], lat);
    if (acc_q.size() == 1 && is_err && err_q.size() == 1)   check({nm, "_err_lat"}, err_q[0] - acc_q[0], lat);
  endtask

  initial begin
    #1 RST = 1'b1;
    repeat (3) @(negedge CLK);
    check("rst_ctrl", {CTRL1, CTRL5, CTRL6}, 0);
    check("rst_we_done_err", {a0_we, done, err}, 0);
    check("rst_iter", iter_count, 0);
    RST = 1'b0;
    @(negedge CLK);
    check("post_rst_ready", instr_ready, 1);

    // LDI then MOVA1 with instr_valid held high throughout
    clear_logs();
    instr = 16'h1abc; instr_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK);
      if (acc_q.size() == 1) instr = 16'h2055;
      if (acc_q.size() == 2) instr_valid = 1'b0;
      if (done_q.size() == 2) break;
    end
    instr_valid = 1'b0;
    check("b2b_accepts", acc_q.size(), 2);
    check("b2b_dones", done_q.size(), 2);
    check("b2b_writes", we_q.size(), 2);
    if (acc_q.size() == 2 && done_q.size() == 2 && we_q.size() == 2) begin
      check("ldi_done_lat", done_q[0] - acc_q[0], 5);
      check("mova1_done_lat", done_q[1] - acc_q[1], 5);
      check("ldi_we_cycle", we_q[0] - acc_q[0], 3);
      check("b2b_accept_gap", acc_q[1] - acc_q[0], 5);
      check("b2b_accept_at_done", acc_q[1] - done_q[0], 0);
      check("ldi_sel", sel_q[0], 3'b100);
      check("mova1_sel", sel_q[1], 3'b010);
    end
    @(negedge CLK);

    run(16'h4003, 0);
    expect_run("repsub3", 9, 3, 0);
    check("repsub3_iter", iter_count, 3);
    if (we_q.size() == 3) begin
      check("repsub3_gap1", we_q[1] - we_q[0], 2);
      check("repsub3_gap2", we_q[2] - we_q[1], 2);
      check("repsub3_sel", {sel_q[0], sel_q[1], sel_q[2]}, 9'b001_001_001);
    end

    run(16'h400a, 2);
    expect_run("repsub10_sz", 7, 2, 0);
    check("repsub10_sz_iter", iter_count, 2);

    run(16'h0000, 0);
    expect_run("nop", 3, 0, 0);
    check("nop_iter_held", iter_count, 2);

    run(16'h4000, 0);
    expect_run("repsub0", 3, 0, 0);
    check("repsub0_iter", iter_count, 0);

    run(16'hf000, 0);
    expect_run("illegal", 2, 0, 1);

    run(16'h1000, 0);
    expect_run("ldi_after_err", 5, 1, 0);

    // Reset while SUB is in EXEC
    clear_logs();
    instr = 16'h3000; instr_valid = 1'b1;
    for (int i = 0; i < 20 && acc_q.size() == 0; i++) @(negedge CLK);
    instr_valid = 1'b0;
    check("rst_sub_accepted", acc_q.size(), 1);
    @(negedge CLK);
    check("rst_pre_ctrl6", CTRL6, 1);
    #1 RST = 1'b1;
    #1;
    check("rst_mid_ctrl", {CTRL1, CTRL5, CTRL6}, 0);
    check("rst_mid_flags", {a0_we, done, err, busy}, 0);
    check("rst_mid_ready", instr_ready, 1);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    clear_logs();
    repeat (8) @(negedge CLK);
    check("rst_no_write_after", we_q.size(), 0);
    check("rst_no_done_after", done_q.size(), 0);
    check("rst_ready_after", instr_ready, 1);

    // Randomized traffic against the model
    begin
      bit will_acc;
      will_acc = 0;
      for (int i = 0; i < 4000; i++) begin
        @(negedge CLK);
        if (will_acc) instr_valid = 1'b0;
        if (!instr_valid && $urandom_range(0, 2) == 0) begin
          int r, op, n;
          logic [15:0] w;
          r = $urandom_range(0, 9);
          if (r <= 3)      op = r;
          else if (r <= 7) op = 4;
          else             op = $urandom_range(5, 15);
          n = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 6);
          w = 16'($urandom);
          w[15:12] = 4'(op);
          w[7:0]   = 8'(n);
          instr = w;
          instr_valid = 1'b1;
        end
        sub_zero = ($urandom_range(0, 5) == 0);
        will_acc = instr_valid && instr_ready;
      end
      @(negedge CLK);
      if (will_acc) instr_valid = 1'b0;
      instr_valid = 1'b0;
      sub_zero = 1'b0;
      repeat (120) @(negedge CLK);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
